// File: rtl/xm_mem_pkg.sv
// Shared definitions for the XMakina memory responder.
// Contents: FSM state encodings, read/write and byte-lane encodings, and a
// byte-enable helper used by the responder.
package xm_mem_pkg;

    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned STATE_W = 2;

    // FSM state encodings
    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT   = 2'd1;
    localparam logic [STATE_W-1:0] ST_ACCESS = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP   = 2'd3;

    // Request direction encoding (memRW_i)
    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    // Byte lane selected by addr[0] (little-endian)
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    // Byte write-enable for a request: word access writes both lanes
    function automatic logic [1:0] lane_be(input logic byte_op, input logic lane);
        if (!byte_op) begin
            return 2'b11;
        end
        return (lane == LANE_HI) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/xm_mem_responder_if.sv
// Memory request/response bus between the XMakina core and the responder.
// Signals:
//   memEn_i   request strobe          memBusy_o  request in progress
//   memRW_i   0 = read, 1 = write     rdValid_o  one-cycle read-data pulse
//   byteOp_i  1 = byte access         rdData_o   read data (held)
//   addr_i    byte address            memErr_o   out-of-range pulse
//   wrData_i  write data
// Modports: master (core side), slave (responder side).
interface xm_mem_responder_if #(
    parameter int unsigned WORD = 16
);
    logic            memEn_i;
    logic            memRW_i;
    logic            byteOp_i;
    logic [WORD-1:0] addr_i;
    logic [WORD-1:0] wrData_i;
    logic            memBusy_o;
    logic            rdValid_o;
    logic [WORD-1:0] rdData_o;
    logic            memErr_o;

    modport master (
        output memEn_i, memRW_i, byteOp_i, addr_i, wrData_i,
        input  memBusy_o, rdValid_o, rdData_o, memErr_o
    );

    modport slave (
        input  memEn_i, memRW_i, byteOp_i, addr_i, wrData_i,
        output memBusy_o, rdValid_o, rdData_o, memErr_o
    );

endinterface

// File: rtl/xm_mem_array.sv
// Synchronous single-port byte-lane RAM for the memory responder.
// Ports:
//   clk_i, arst_i  clock / async active-high reset (read register only)
//   wr_en          write cycle, lanes selected by be[1:0]
//   be             byte write-enable, be[0] = [7:0], be[1] = [15:8]
//   rd_en          read cycle, rd_data updated at this edge
//   rd_byte        return one lane zero-extended instead of the full word
//   rd_lane        lane for a byte read
//   rd_zero        force the read result to 0 (out-of-range access)
//   idx, wdata     word index and write data
//   rd_data        registered read data, held between reads
module xm_mem_array
    import xm_mem_pkg::*;
#(
    parameter int unsigned WORD      = 16,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned IDX_W     = 10,
    parameter string       INIT_FILE = ""
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             wr_en,
    input  logic [1:0]       be,
    input  logic             rd_en,
    input  logic             rd_byte,
    input  logic             rd_lane,
    input  logic             rd_zero,
    input  logic [IDX_W-1:0] idx,
    input  logic [WORD-1:0]  wdata,
    output logic [WORD-1:0]  rd_data
);

    logic [WORD-1:0]   mem [DEPTH];
    logic [BYTE_W-1:0] lane_c;

    // Lane-masked write
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            if (be[0]) begin
                mem[idx][BYTE_W-1:0] <= wdata[BYTE_W-1:0];
            end
            if (be[1]) begin
                mem[idx][2*BYTE_W-1:BYTE_W] <= wdata[2*BYTE_W-1:BYTE_W];
            end
        end
    end

    assign lane_c = (rd_lane == LANE_HI) ? mem[idx][2*BYTE_W-1:BYTE_W]
                                         : mem[idx][BYTE_W-1:0];

    // Read register: formatted here so the responder output stays registered
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rd_data <= '0;
        end else if (rd_en) begin
            if (rd_zero) begin
                rd_data <= '0;
            end else if (rd_byte) begin
                rd_data <= WORD'(lane_c);
            end else begin
                rd_data <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/xm_mem_responder.sv
// Memory-side responder for the XMakina multi-cycle core.
// Accepts one request at a time, holds memBusy_o for WAIT_CYCLES wait states
// plus one access cycle, then performs the access on xm_mem_array and, for a
// read, pulses rdValid_o for one cycle with rdData_o valid.
// Ports:
//   clk_i   clock, rising edge
//   arst_i  asynchronous active-high reset
//   bus     xm_mem_responder_if.slave (request in, busy/read data/error out)
// Build option: define XM_MEM_ERR_EN to flag word indices >= DEPTH (write
// dropped, read returns 0, memErr_o pulses). Without it the index wraps
// modulo DEPTH and memErr_o is tied 0.
module xm_mem_responder
    import xm_mem_pkg::*;
#(
    parameter int unsigned WORD        = 16,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic                clk_i,
    input  logic                arst_i,
    xm_mem_responder_if.slave   bus
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned WAIT_LOAD = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               latch_c;
    logic               busy_q, busy_d;
    logic               valid_q, valid_d;

    // Latched request
    logic               rw_q;
    logic               byte_q;
    logic [WORD-1:0]    addr_q;
    logic [WORD-1:0]    wdata_q;

    logic [WORD-2:0]    idx_full_c;
    logic [IDX_W-1:0]   idx_c;
    logic               oor_c;
    logic               access_c;
    logic               wr_en_c;
    logic               rd_en_c;
    logic [1:0]         be_c;
    logic [WORD-1:0]    ram_wdata_c;
    logic [WORD-1:0]    ram_rdata;

    assign idx_full_c = addr_q[WORD-1:1];
    assign idx_c      = idx_full_c[IDX_W-1:0];

`ifdef XM_MEM_ERR_EN
    logic err_q;

    assign oor_c = (32'(idx_full_c) >= DEPTH);

    // Error pulse lands in RESP alongside rdValid_o
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access_c && oor_c;
        end
    end

    assign bus.memErr_o = err_q;
`else
    logic unused_idx_hi;

    assign oor_c         = 1'b0;
    assign unused_idx_hi = ^idx_full_c[WORD-2:IDX_W];
    assign bus.memErr_o  = 1'b0;
`endif

    // RAM controls: everything is taken from the latched request
    assign access_c    = (state_q == ST_ACCESS);
    assign wr_en_c     = access_c && (rw_q == MEM_WRITE) && !oor_c;
    assign rd_en_c     = access_c && (rw_q == MEM_READ);
    assign be_c        = lane_be(byte_q, addr_q[0]);
    assign ram_wdata_c = byte_q ? WORD'({2{wdata_q[BYTE_W-1:0]}}) : wdata_q;

    // Next state, wait counter and registered-output next values
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        latch_c = 1'b0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (bus.memEn_i) begin
                    latch_c = 1'b1;
                    busy_d  = 1'b1;
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_LOAD);
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_WAIT: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
                valid_d = (rw_q == MEM_READ);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, outputs and request latch
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            rw_q    <= MEM_READ;
            byte_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            if (latch_c) begin
                rw_q    <= bus.memRW_i;
                byte_q  <= bus.byteOp_i;
                addr_q  <= bus.addr_i;
                wdata_q <= bus.wrData_i;
            end
        end
    end

    xm_mem_array #(
        .WORD      (WORD),
        .DEPTH     (DEPTH),
        .IDX_W     (IDX_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .wr_en   (wr_en_c),
        .be      (be_c),
        .rd_en   (rd_en_c),
        .rd_byte (byte_q),
        .rd_lane (addr_q[0]),
        .rd_zero (oor_c),
        .idx     (idx_c),
        .wdata   (ram_wdata_c),
        .rd_data (ram_rdata)
    );

    assign bus.memBusy_o = busy_q;
    assign bus.rdValid_o = valid_q;
    assign bus.rdData_o  = ram_rdata;

endmodule

// File: tb/tb_xm_mem_responder.sv
// Bench for xm_mem_responder: dut_a uses WAIT_CYCLES = 2, dut_b uses
// WAIT_CYCLES = 0 for back-to-back reads. Read expectations go into a
// per-DUT queue and are compared whenever rdValid_o is seen.
module tb_xm_mem_responder;

    localparam int unsigned W_A = 2;
    localparam int unsigned W_B = 0;
    localparam logic RD = 1'b0;
    localparam logic WR = 1'b1;
`ifdef XM_MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic arst;

    int errors = 0;
    int checks = 0;

    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] last_rd [2];
    logic [15:0] exp_a, exp_b;

    xm_mem_responder_if #(.WORD(16)) bus_a ();
    xm_mem_responder_if #(.WORD(16)) bus_b ();

    xm_mem_responder #(.WORD(16), .DEPTH(1024), .WAIT_CYCLES(W_A)) dut_a (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus_a)
    );

    xm_mem_responder #(.WORD(16), .DEPTH(1024), .WAIT_CYCLES(W_B)) dut_b (
        .clk_i  (clk),
        .arst_i (arst),
        .bus    (bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic drive(input int sel, input logic en, input logic rw, input logic bt,
                         input logic [15:0] addr, input logic [15:0] wdat);
        if (sel == 0) begin
            bus_a.memEn_i  = en;
            bus_a.memRW_i  = rw;
            bus_a.byteOp_i = bt;
            bus_a.addr_i   = addr;
            bus_a.wrData_i = wdat;
        end else begin
            bus_b.memEn_i  = en;
            bus_b.memRW_i  = rw;
            bus_b.byteOp_i = bt;
            bus_b.addr_i   = addr;
            bus_b.wrData_i = wdat;
        end
    endtask

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? bus_a.memBusy_o : bus_b.memBusy_o;
    endfunction

    function automatic logic get_valid(input int sel);
        return (sel == 0) ? bus_a.rdValid_o : bus_b.rdValid_o;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus_a.memErr_o : bus_b.memErr_o;
    endfunction

    function automatic logic [15:0] get_data(input int sel);
        return (sel == 0) ? bus_a.rdData_o : bus_b.rdData_o;
    endfunction

    // One complete request; inputs are scrambled right after acceptance
    task automatic access(input int sel, input logic rw, input logic bt,
                          input logic [15:0] addr, input logic [15:0] wdat,
                          input logic [15:0] exp_rd, input logic exp_err);
        int w;
        int busy_cnt;
        w = (sel == 0) ? W_A : W_B;
        @(posedge clk);
        #1;
        drive(sel, 1'b1, rw, bt, addr, wdat);
        if (rw == RD) begin
            if (sel == 0) qa.push_back(exp_rd);
            else          qb.push_back(exp_rd);
            last_rd[sel] = exp_rd;
        end
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
        busy_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (get_busy(sel)) busy_cnt++;
            else break;
        end
        check("busy_len", 32'(busy_cnt), 32'(w + 1));
        check("rd_valid_resp", 32'(get_valid(sel)), 32'(rw == RD));
        check("mem_err_resp", 32'(get_err(sel)), 32'(exp_err));
        if (rw == WR) begin
            check("write_keeps_rd_data", 32'(get_data(sel)), 32'(last_rd[sel]));
        end
        @(negedge clk);
        check("rd_valid_one_cycle", 32'(get_valid(sel)), 32'd0);
        check("mem_err_one_cycle", 32'(get_err(sel)), 32'd0);
    endtask

    // Scoreboard: compare read data whenever a DUT reports valid
    always @(negedge clk) begin
        if (!arst && bus_a.rdValid_o) begin
            check("a_sb_nonempty", 32'(qa.size() != 0), 32'd1);
            if (qa.size() != 0) begin
                exp_a = qa.pop_front();
                check("a_rd_data", 32'(bus_a.rdData_o), 32'(exp_a));
            end
        end
        if (!arst && bus_b.rdValid_o) begin
            check("b_sb_nonempty", 32'(qb.size() != 0), 32'd1);
            if (qb.size() != 0) begin
                exp_b = qb.pop_front();
                check("b_rd_data", 32'(bus_b.rdData_o), 32'(exp_b));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst = 1'b1;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        drive(0, 1'b0, RD, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, RD, 1'b0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            check("reset_busy", 32'(get_busy(s)), 32'd0);
            check("reset_valid", 32'(get_valid(s)), 32'd0);
            check("reset_err", 32'(get_err(s)), 32'd0);
            check("reset_rd_data", 32'(get_data(s)), 32'd0);
        end
        arst = 1'b0;

        // Word write then read, plus word access ignoring addr[0]
        access(0, WR, 1'b0, 16'h0010, 16'hBEEF, 16'h0, 1'b0);
        access(0, RD, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 1'b0);
        access(0, RD, 1'b0, 16'h0011, 16'h0, 16'hBEEF, 1'b0);

        // Byte lanes
        access(0, WR, 1'b0, 16'h0020, 16'h1234, 16'h0, 1'b0);
        access(0, WR, 1'b1, 16'h0021, 16'h77AB, 16'h0, 1'b0);
        access(0, RD, 1'b0, 16'h0020, 16'h0, 16'hAB34, 1'b0);
        access(0, RD, 1'b1, 16'h0020, 16'h0, 16'h0034, 1'b0);
        access(0, RD, 1'b1, 16'h0021, 16'h0, 16'h00AB, 1'b0);
        access(0, WR, 1'b1, 16'h0020, 16'h55CD, 16'h0, 1'b0);
        access(0, RD, 1'b0, 16'h0020, 16'h0, 16'hABCD, 1'b0);

        // Reset during WAIT aborts the write
        access(0, WR, 1'b0, 16'h0040, 16'h1357, 16'h0, 1'b0);
        access(0, RD, 1'b0, 16'h0040, 16'h0, 16'h1357, 1'b0);
        @(posedge clk);
        #1;
        drive(0, 1'b1, WR, 1'b0, 16'h0040, 16'h5555);
        @(posedge clk);
        #1;
        drive(0, 1'b0, RD, 1'b0, 16'h0, 16'h0);
        @(negedge clk);
        check("midop_busy_before_rst", 32'(bus_a.memBusy_o), 32'd1);
        arst = 1'b1;
        #1;
        check("midop_rst_busy", 32'(bus_a.memBusy_o), 32'd0);
        check("midop_rst_valid", 32'(bus_a.rdValid_o), 32'd0);
        check("midop_rst_err", 32'(bus_a.memErr_o), 32'd0);
        check("midop_rst_data", 32'(bus_a.rdData_o), 32'd0);
        @(negedge clk);
        arst = 1'b0;
        last_rd[0] = 16'h0;
        last_rd[1] = 16'h0;
        access(0, RD, 1'b0, 16'h0040, 16'h0, 16'h1357, 1'b0);

        // Range boundary and out-of-range handling
        access(0, WR, 1'b0, 16'h0000, 16'hC0DE, 16'h0, 1'b0);
        access(0, WR, 1'b0, 16'h07FE, 16'h4242, 16'h0, 1'b0);
        access(0, RD, 1'b0, 16'h07FE, 16'h0, 16'h4242, 1'b0);
        access(0, RD, 1'b0, 16'h0800, 16'h0, ERR_EN ? 16'h0000 : 16'hC0DE, ERR_EN);
        access(0, WR, 1'b0, 16'h0800, 16'hFFFF, 16'h0, ERR_EN);
        access(0, RD, 1'b0, 16'h0000, 16'h0, ERR_EN ? 16'hC0DE : 16'hFFFF, 1'b0);

        // Zero wait states: preload, then back-to-back reads with memEn_i held
        access(1, WR, 1'b0, 16'h0000, 16'hA5A5, 16'h0, 1'b0);
        access(1, WR, 1'b0, 16'h0002, 16'h5A5A, 16'h0, 1'b0);
        access(1, RD, 1'b0, 16'h0002, 16'h0, 16'h5A5A, 1'b0);
        @(posedge clk);
        #1;
        drive(1, 1'b1, RD, 1'b0, 16'h0000, 16'h0);
        qb.push_back(16'hA5A5);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (i < 3) begin
                drive(1, 1'b1, RD, 1'b0, (i % 2 == 0) ? 16'h0002 : 16'h0000, 16'h0);
                qb.push_back((i % 2 == 0) ? 16'h5A5A : 16'hA5A5);
            end else begin
                drive(1, 1'b0, RD, 1'b0, 16'h0, 16'h0);
            end
            @(negedge clk);
            check("b2b_busy_access", 32'(bus_b.memBusy_o), 32'd1);
            check("b2b_valid_access", 32'(bus_b.rdValid_o), 32'd0);
            @(posedge clk);
            @(negedge clk);
            check("b2b_busy_resp", 32'(bus_b.memBusy_o), 32'd0);
            check("b2b_valid_resp", 32'(bus_b.rdValid_o), 32'd1);
        end
        @(negedge clk);
        check("b2b_idle_busy", 32'(bus_b.memBusy_o), 32'd0);
        check("b2b_idle_valid", 32'(bus_b.rdValid_o), 32'd0);

        repeat (2) @(negedge clk);
        check("a_sb_drained", 32'(qa.size()), 32'd0);
        check("b_sb_drained", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
